data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Two-requester arbiter for the single-port data memory (MEM_DATA, 1-cycle sync read).
//  Port 0 = CPU data side (DataAdr/WriteData/MemWrite), port 1 = DMA/secondary master.
//  Round-robin with bounded bursts; routes read data back to the issuing port with a valid pulse.
//  Sits between the masters and the chipSet/RAM path; the RAM sees exactly one command per cycle.
// PARAMETERS
//  AW        8   address width presented to memory (low bits of DataAdr)
//  DW        32  data width
//  RD_LAT    1   cycles from read beat to mem_rdata valid (>=1)
//  MAX_BURST 4   max consecutive beats for one owner while the other port requests (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-low
//  m0_req     in   1   port 0 request; m0_we/addr/wdata held stable until m0_gnt
//  m0_we      in   1   port 0 write (1) / read (0)
//  m0_addr    in   AW  port 0 address
//  m0_wdata   in   DW  port 0 write data
//  m0_gnt     out  1   beat accepted this cycle for port 0
//  m0_rvalid  out  1   m0_rdata valid (one pulse per read beat)
//  m0_rdata   out  DW  read data to port 0
//  m1_*       --   --  identical set for port 1
//  mem_addr   out  AW  memory address
//  mem_we     out  1   memory write enable
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data (RD_LAT after read beat)
//  owner      out  1   current owner index (valid when busy)
//  busy       out  1   FSM in OWN0/OWN1
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, last_owner=1, beat_cnt=0, rvalid pipe cleared.
//   All outputs 0; pending reads dropped, no rvalid after reset.
//  FSM states: IDLE, OWN0, OWN1 (registered). Decision uses current-cycle req, takes effect next cycle.
//  IDLE: mem_we=0, mem_addr=0, mem_wdata=0, no gnt. Next state:
//   only m0_req -> OWN0; only m1_req -> OWN1;
//   both -> port != last_owner; none -> IDLE. IDLE-to-first-beat latency = 1 cycle.
//  OWNx: mem_addr/mem_wdata = mx_addr/mx_wdata (combinational mux), mem_we = mx_req & mx_we.
//   mx_gnt = mx_req. Each cycle with mx_req=1 is one beat; beat_cnt++.
//   last_owner <= x on every beat.
//  OWNx exit (evaluated each cycle, y = other port):
//   mx_req=0: -> OWNy if my_req else IDLE. No beat issued; mem_we=0.
//   mx_req=1 & beat_cnt==MAX_BURST-1 & my_req: this beat issues, then -> OWNy.
//   Otherwise stay in OWNx.
//   beat_cnt clears on every state change. While my_req=0, beat_cnt saturates at MAX_BURST-1.
//  Handoff OWNx->OWNy is direct: no dead cycle, and y's first beat is in the next cycle.
//  MAX_BURST=1 with both requesting: strict alternation, one beat each.
//  Read return:
//   - RD_LAT-deep shift pipe of {valid, port} pushed on every read beat.
//   - At the pipe output: mP_rvalid=1 for one cycle.
//   - m0_rdata = m1_rdata = mem_rdata (broadcast); only rvalid qualifies.
//   - Writes push valid=0.
//   - Reads in flight still return after an ownership change; ordering follows issue order.
//  Masters must not drop req or change command before gnt. Violations are not detected.
//  owner = (state==OWN1); busy = (state!=IDLE). Both are registered, so no glitches.
// TESTING
//  Reset then m0_req=1, we=0, addr=0x10 for 1 beat:
//   -> gnt0 at cycle 2, mem_addr=0x10, mem_we=0, m0_rvalid pulse at cycle 3.
//  m0 write addr=0x04 data=0xDEADBEEF, then m0 read 0x04:
//   -> mem_we pulse with that data; m0_rdata=0xDEADBEEF with m0_rvalid, m1_rvalid=0.
//  Both req continuously from reset, MAX_BURST=4:
//   -> gnt pattern 0,0,0,0,1,1,1,1,0...; no idle cycle between owners.
//  m1 alone streams 10 beats:
//   -> 10 consecutive gnt1, no forced switch.
//   m0 raises req at beat 6 -> at most 4 more m1 beats, then m0 granted.
//  m1 read at addr 0x20 followed by handoff to m0 write:
//   -> m1_rvalid arrives during OWN0; m0_rvalid stays 0.
//  Assert rst=0 mid-burst with a read in flight:
//   -> all outputs 0 immediately, no rvalid after release.
//   After release, both req -> m0 granted first.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data side (port 0)
// and a secondary master (port 1), with bounded bursts and read data routed back by port.
module data_mem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state, nextState, otherState;
    logic            lastOwner, nextLastOwner;
    logic [CW-1:0]   beatCnt, nextBeatCnt;
    logic            curReq, curWe, otherReq;
    logic [AW-1:0]   curAddr;
    logic [DW-1:0]   curWdata;
    logic            owning;
    logic            beat;
    logic [RD_LAT-1:0] pipeValid;
    logic [RD_LAT-1:0] pipePort;

    // Present the current owner's command as "cur" and the waiting port as "other".
    always_comb begin
        curReq     = m0_req;
        curWe      = m0_we;
        curAddr    = m0_addr;
        curWdata   = m0_wdata;
        otherReq   = m1_req;
        otherState = OWN1;
        if (state == OWN1) begin
            curReq     = m1_req;
            curWe      = m1_we;
            curAddr    = m1_addr;
            curWdata   = m1_wdata;
            otherReq   = m0_req;
            otherState = OWN0;
        end
    end

    assign owning    = (state == OWN0) || (state == OWN1);
    assign beat      = owning && curReq;
    assign mem_addr  = owning ? curAddr : '0;
    assign mem_wdata = owning ? curWdata : '0;
    assign mem_we    = beat && curWe;
    assign m0_gnt    = (state == OWN0) && m0_req;
    assign m1_gnt    = (state == OWN1) && m1_req;

    always_comb begin
        nextState     = state;
        nextBeatCnt   = beatCnt;
        nextLastOwner = lastOwner;
        case (state)
            IDLE: begin
                if (m0_req && m1_req)
                    nextState = lastOwner ? OWN0 : OWN1;
                else if (m0_req)
                    nextState = OWN0;
                else if (m1_req)
                    nextState = OWN1;
            end
            OWN0, OWN1: begin
                if (!curReq) begin
                    nextState = otherReq ? otherState : IDLE;
                end else begin
                    nextLastOwner = (state == OWN1);
                    // The counter saturates on the last beat so a late requester waits at most one beat.
                    if (beatCnt == LAST_BEAT && otherReq)
                        nextState = otherState;
                    else if (beatCnt != LAST_BEAT)
                        nextBeatCnt = beatCnt + CW'(1);
                end
            end
            default: nextState = IDLE;
        endcase
        if (nextState != state)
            nextBeatCnt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lastOwner <= 1'b1;
            beatCnt   <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nextState;
            lastOwner <= nextLastOwner;
            beatCnt   <= nextBeatCnt;
            owner     <= (nextState == OWN1);
            busy      <= (nextState != IDLE);
        end
    end

    // Tag each read beat with its issuing port so data returns to the right master after a handoff.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipeValid <= '0;
            pipePort  <= '0;
        end else begin
            pipeValid[0] <= beat && !curWe;
            pipePort[0]  <= (state == OWN1);
            for (int i = 1; i < RD_LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipePort[i]  <= pipePort[i-1];
            end
        end
    end

    assign m0_rvalid = pipeValid[RD_LAT-1] && !pipePort[RD_LAT-1];
    assign m1_rvalid = pipeValid[RD_LAT-1] &&  pipePort[RD_LAT-1];
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a tenure/queue model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_data_mem_arbiter;

    localparam int MAX_BURST = 4;
    localparam int RD_LAT    = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0]  m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        owner, busy;

    int checkCount = 0;
    int failCount  = 0;

    data_mem_arbiter #(.AW(8), .DW(32), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle synchronous read.
    logic [31:0] memArr [0:255];
    always @(posedge clk) begin
        if (mem_we)
            memArr[mem_addr] <= mem_wdata;
        mem_rdata <= memArr[mem_addr];
    end

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rdEntry_t;

    rdEntry_t    rq[$];
    logic [31:0] shadow [0:255];
    int          holder = -1;
    int          run    = 0;
    int          last   = 1;
    int          cyc    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Tenure model: the holder keeps the memory while it requests, and yields once it has had
    // MAX_BURST beats in this tenure and the other port is waiting.
    task automatic modelStep();
        logic       r[2], w[2];
        logic [7:0] a[2];
        logic [31:0] d[2];
        int nxt, x, y;
        if (!rst) begin
            holder = -1;
            run    = 0;
            last   = 1;
            rq.delete();
            return;
        end
        r[0] = m0_req; w[0] = m0_we; a[0] = m0_addr; d[0] = m0_wdata;
        r[1] = m1_req; w[1] = m1_we; a[1] = m1_addr; d[1] = m1_wdata;
        nxt = holder;
        if (holder < 0) begin
            if (r[0] && r[1]) nxt = 1 - last;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
            run = 0;
        end else begin
            x = holder;
            y = 1 - x;
            if (!r[x]) begin
                nxt = r[y] ? y : -1;
                run = 0;
            end else begin
                last = x;
                run++;
                if (w[x]) shadow[a[x]] = d[x];
                else      rq.push_back('{due: cyc + RD_LAT, port: x, data: shadow[a[x]]});
                if (run >= MAX_BURST && r[y]) begin
                    nxt = y;
                    run = 0;
                end
            end
        end
        holder = nxt;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            memArr[i] = '0;
            shadow[i] = '0;
        end
        forever begin
            @(posedge clk or negedge rst);
            modelStep();
        end
    end

    // Compare every DUT output against the model in the middle of each cycle.
    task automatic compareStep();
        logic        eG0, eG1, eWe, eBusy, eOwn, eR0, eR1;
        logic [7:0]  eAddr;
        logic [31:0] eWd, eData;
        eG0 = 0; eG1 = 0; eWe = 0; eBusy = 0; eOwn = 0; eR0 = 0; eR1 = 0;
        eAddr = '0; eWd = '0; eData = '0;
        if (rst) begin
            if (holder == 0) begin
                eG0 = m0_req; eWe = m0_req & m0_we; eAddr = m0_addr; eWd = m0_wdata; eBusy = 1;
            end else if (holder == 1) begin
                eG1 = m1_req; eWe = m1_req & m1_we; eAddr = m1_addr; eWd = m1_wdata; eBusy = 1; eOwn = 1;
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                eR0   = (rq[0].port == 0);
                eR1   = (rq[0].port == 1);
                eData = rq[0].data;
                void'(rq.pop_front());
            end
        end
        checkOutput("cmp m0_gnt", m0_gnt, eG0);
        checkOutput("cmp m1_gnt", m1_gnt, eG1);
        checkOutput("cmp mem_we", mem_we, eWe);
        checkOutput("cmp mem_addr", mem_addr, eAddr);
        checkOutput("cmp mem_wdata", mem_wdata, eWd);
        checkOutput("cmp busy", busy, eBusy);
        checkOutput("cmp owner", owner, eOwn);
        checkOutput("cmp m0_rvalid", m0_rvalid, eR0);
        checkOutput("cmp m1_rvalid", m1_rvalid, eR1);
        if (eR0) checkOutput("cmp m0_rdata", m0_rdata, eData);
        if (eR1) checkOutput("cmp m1_rdata", m1_rdata, eData);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compareStep();
        end
    end

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [7:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    int g1Count, m1Late, firstM0, pat;
    logic prevG1;
    int expPat [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;

        // Single read from port 0 out of idle.
        cycle();
        applyStimulus(0, 1, 0, 8'h10, 32'h0);
        @(negedge clk);
        checkOutput("t1 idle gnt0", m0_gnt, 1'b0);
        cycle();
        @(negedge clk);
        checkOutput("t1 gnt0", m0_gnt, 1'b1);
        checkOutput("t1 mem_addr", mem_addr, 8'h10);
        checkOutput("t1 mem_we", mem_we, 1'b0);
        cycle();
        applyStimulus(0, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        checkOutput("t1 m0_rvalid", m0_rvalid, 1'b1);
        checkOutput("t1 m1_rvalid", m1_rvalid, 1'b0);
        cycle();
        cycle();

        // Port 0 write then read back.
        applyStimulus(0, 1, 1, 8'h04, 32'hDEADBEEF);
        @(negedge clk);
        cycle();
        @(negedge clk);
        checkOutput("t2 mem_we", mem_we, 1'b1);
        checkOutput("t2 mem_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("t2 mem_addr", mem_addr, 8'h04);
        cycle();
        applyStimulus(0, 1, 0, 8'h04, 32'h0);
        @(negedge clk);
        checkOutput("t2 read gnt0", m0_gnt, 1'b1);
        cycle();
        applyStimulus(0, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        checkOutput("t2 m0_rvalid", m0_rvalid, 1'b1);
        checkOutput("t2 m0_rdata", m0_rdata, 32'hDEADBEEF);
        checkOutput("t2 m1_rvalid", m1_rvalid, 1'b0);
        cycle();
        cycle();

        // Port 1 streams ten writes on its own.
        applyStimulus(1, 1, 1, 8'h40, 32'h10000000);
        @(negedge clk);
        g1Count = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i > 0) applyStimulus(1, 1, 1, 8'(8'h40 + i), 32'h10000000 + i);
            @(negedge clk);
            if (m1_gnt) g1Count++;
        end
        cycle();
        applyStimulus(1, 0, 0, 8'h00, 32'h0);
        checkOutput("t4 stream beats", g1Count, 10);
        cycle();
        cycle();

        // Port 1 streams again; port 0 arrives during beat 6.
        applyStimulus(1, 1, 1, 8'h60, 32'h20000000);
        @(negedge clk);
        prevG1 = 0; m1Late = 0; firstM0 = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (prevG1) applyStimulus(1, 1, 1, 8'(8'h60 + i), 32'h20000000 + i);
            if (i == 6) applyStimulus(0, 1, 0, 8'h04, 32'h0);
            if (i == 8) applyStimulus(0, 0, 0, 8'h00, 32'h0);
            @(negedge clk);
            prevG1 = m1_gnt;
            if (i >= 6 && m1_gnt) m1Late++;
            if (m0_gnt && firstM0 == 0) firstM0 = i;
        end
        checkOutput("t4 m1 beats after m0 req", m1Late, 1);
        checkOutput("t4 first m0 gnt cycle", firstM0, 7);
        cycle();
        @(negedge clk);
        checkOutput("t4 m1 resumes", m1_gnt, 1'b1);
        cycle();
        applyStimulus(1, 0, 0, 8'h00, 32'h0);
        cycle();
        cycle();

        // Port 1 read as the last beat of a burst; data returns while port 0 owns the memory.
        applyStimulus(1, 1, 1, 8'h20, 32'hA0000020);
        @(negedge clk);
        cycle();
        cycle();
        applyStimulus(1, 1, 1, 8'h21, 32'hA0000021);
        cycle();
        applyStimulus(1, 1, 1, 8'h22, 32'hA0000022);
        cycle();
        applyStimulus(1, 1, 0, 8'h20, 32'h0);
        applyStimulus(0, 1, 1, 8'h08, 32'h12345678);
        @(negedge clk);
        checkOutput("t5 m1 read gnt", m1_gnt, 1'b1);
        checkOutput("t5 read addr", mem_addr, 8'h20);
        cycle();
        applyStimulus(1, 0, 0, 8'h00, 32'h0);
        @(negedge clk);
        checkOutput("t5 m0 gnt", m0_gnt, 1'b1);
        checkOutput("t5 owner", owner, 1'b0);
        checkOutput("t5 m1_rvalid", m1_rvalid, 1'b1);
        checkOutput("t5 m1_rdata", m1_rdata, 32'hA0000020);
        checkOutput("t5 m0_rvalid", m0_rvalid, 1'b0);
        cycle();
        applyStimulus(0, 0, 0, 8'h00, 32'h0);
        cycle();
        cycle();

        // Both ports request continuously from reset.
        rst = 1'b0;
        applyStimulus(0, 1, 0, 8'h04, 32'h0);
        applyStimulus(1, 1, 0, 8'h20, 32'h0);
        cycle();
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            @(negedge clk);
            pat = m0_gnt ? 1 : (m1_gnt ? 2 : 0);
            checkOutput("t3 gnt pattern", pat, expPat[i]);
        end

        // Reset in the middle of a port 1 read beat.
        cycle();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("t6 m0_gnt", m0_gnt, 1'b0);
        checkOutput("t6 m1_gnt", m1_gnt, 1'b0);
        checkOutput("t6 busy", busy, 1'b0);
        checkOutput("t6 owner", owner, 1'b0);
        checkOutput("t6 mem_we", mem_we, 1'b0);
        checkOutput("t6 mem_addr", mem_addr, 8'h00);
        checkOutput("t6 mem_wdata", mem_wdata, 32'h0);
        checkOutput("t6 m0_rvalid", m0_rvalid, 1'b0);
        checkOutput("t6 m1_rvalid", m1_rvalid, 1'b0);
        cycle();
        @(negedge clk);
        #2 rst = 1'b1;
        cycle();
        @(negedge clk);
        checkOutput("t6 m0 first", m0_gnt, 1'b1);
        checkOutput("t6 m1 waits", m1_gnt, 1'b0);
        checkOutput("t6 no m1_rvalid", m1_rvalid, 1'b0);
        repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
